alu: RTL and testbench

- Registered 8-bit ALU: two operands, one of 16 operations chosen by a 4-bit select.
- Covers add, subtract, multiply, compare, bitwise logic, shift and rotate.
- Result, multiplier high byte and a 4-bit status register update on the clock edge.
- Sits as the datapath execution unit; a free-running clock generator drives its clk.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_shifter.sv | 64 ++++++
 rtl/alu.sv | 132 +++++++++++++
 tb/tb_alu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcodes, status-flag bit positions and default width.
// Optional build macro used by this block: ALU_SHIFT_CARRY_EN (see alu.sv).
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SAR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_NAND = 4'd13;
    localparam logic [3:0] OP_NOR  = 4'd14;
    localparam logic [3:0] OP_XNOR = 4'd15;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter/rotator for SHL/SHR/SAR/ROL/ROR, with optional last-bit-out carry.
// The carry output is forced to 0 unless CARRY_EN is set (driven from ALU_SHIFT_CARRY_EN by alu.sv).
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH    = ALU_WIDTH,
    parameter bit CARRY_EN = 1'b0,
    localparam int SH_W    = $clog2(WIDTH)
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [SH_W-1:0]  amt,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    // One guard bit beyond the data catches the last bit shifted out.
    logic [WIDTH:0]          shl_w;
    logic [WIDTH:0]          shr_w;
    logic signed [WIDTH:0]   sar_w;
    logic [2*WIDTH-1:0]      rol_w;
    logic [2*WIDTH-1:0]      ror_w;
    logic                    carry_raw;

    assign shl_w = {1'b0, a} << amt;
    assign shr_w = {a, 1'b0} >> amt;
    assign sar_w = $signed({a, 1'b0}) >>> amt;
    assign rol_w = {a, a} << amt;
    assign ror_w = {a, a} >> amt;

    always_comb begin
        result    = '0;
        carry_raw = 1'b0;
        case (op)
            OP_SHL: begin
                result    = shl_w[WIDTH-1:0];
                carry_raw = shl_w[WIDTH];
            end
            OP_SHR: begin
                result    = shr_w[WIDTH:1];
                carry_raw = shr_w[0];
            end
            OP_SAR: begin
                result    = sar_w[WIDTH:1];
                carry_raw = sar_w[0];
            end
            OP_ROL: begin
                result    = rol_w[2*WIDTH-1:WIDTH];
                carry_raw = rol_w[WIDTH];
            end
            OP_ROR: begin
                result    = ror_w[WIDTH-1:0];
                carry_raw = ror_w[WIDTH-1];
            end
            default: begin
                result    = '0;
                carry_raw = 1'b0;
            end
        endcase
        // A zero shift moves nothing out, so there is no carry.
        carry = CARRY_EN && (amt != '0) && carry_raw;
    end

endmodule

// File: rtl/alu.sv
// Registered ALU: 16 operations on two WIDTH-bit operands, result/product-high/flags captured each clock.
// Define ALU_SHIFT_CARRY_EN to have shifts and rotates report the last bit moved out in C.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       function_select_lines,
    output logic [WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0] mul_high,
    output logic [3:0]       SREG
);

    localparam int SH_W = $clog2(WIDTH);
`ifdef ALU_SHIFT_CARRY_EN
    localparam bit SHIFT_CARRY_EN = 1'b1;
`else
    localparam bit SHIFT_CARRY_EN = 1'b0;
`endif

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prod;
    logic                 add_v;
    logic                 sub_v;
    logic                 cmp_lt;
    logic                 cmp_eq;
    logic                 cmp_gt;
    logic [WIDTH-1:0]     shift_res;
    logic                 shift_c;

    logic [WIDTH-1:0]     reg_out_d, reg_out_q;
    logic [WIDTH-1:0]     mul_high_d, mul_high_q;
    logic [3:0]           sreg_d, sreg_q;
    logic [WIDTH-1:0]     zn_src;
    logic                 c_flag;
    logic                 v_flag;

    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

    // Signed overflow: operands agree (add) or differ (sub) in sign and the result sign differs from A.
    assign add_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

    assign cmp_lt = diff[WIDTH];
    assign cmp_eq = (A == B);
    assign cmp_gt = !cmp_lt && !cmp_eq;

    alu_shifter #(
        .WIDTH    (WIDTH),
        .CARRY_EN (SHIFT_CARRY_EN)
    ) u_shifter (
        .op     (function_select_lines),
        .a      (A),
        .amt    (B[SH_W-1:0]),
        .result (shift_res),
        .carry  (shift_c)
    );

    always_comb begin
        reg_out_d  = '0;
        mul_high_d = '0;
        c_flag     = 1'b0;
        v_flag     = 1'b0;
        case (function_select_lines)
            OP_ADD: begin
                reg_out_d = sum[WIDTH-1:0];
                c_flag    = sum[WIDTH];
                v_flag    = add_v;
            end
            OP_SUB: begin
                reg_out_d = diff[WIDTH-1:0];
                c_flag    = diff[WIDTH];
                v_flag    = sub_v;
            end
            OP_MUL: begin
                reg_out_d  = prod[WIDTH-1:0];
                mul_high_d = prod[2*WIDTH-1:WIDTH];
                c_flag     = |prod[2*WIDTH-1:WIDTH];
                v_flag     = |prod[2*WIDTH-1:WIDTH];
            end
            OP_CMP: begin
                reg_out_d = {{(WIDTH-3){1'b0}}, cmp_gt, cmp_eq, cmp_lt};
                c_flag    = diff[WIDTH];
                v_flag    = sub_v;
            end
            OP_AND:  reg_out_d = A & B;
            OP_OR:   reg_out_d = A | B;
            OP_XOR:  reg_out_d = A ^ B;
            OP_NOT:  reg_out_d = ~A;
            OP_NAND: reg_out_d = ~(A & B);
            OP_NOR:  reg_out_d = ~(A | B);
            OP_XNOR: reg_out_d = ~(A ^ B);
            default: begin
                reg_out_d = shift_res;
                c_flag    = shift_c;
            end
        endcase

        // CMP reports Z/N of the underlying subtraction, not of its encoded result.
        zn_src = (function_select_lines == OP_CMP) ? diff[WIDTH-1:0] : reg_out_d;

        sreg_d         = '0;
        sreg_d[FLAG_C] = c_flag;
        sreg_d[FLAG_Z] = (zn_src == '0);
        sreg_d[FLAG_N] = zn_src[WIDTH-1];
        sreg_d[FLAG_V] = v_flag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_out_q  <= '0;
            mul_high_q <= '0;
            sreg_q     <= '0;
        end else begin
            reg_out_q  <= reg_out_d;
            mul_high_q <= mul_high_d;
            sreg_q     <= sreg_d;
        end
    end

    assign reg_out  = reg_out_q;
    assign mul_high = mul_high_q;
    assign SREG     = sreg_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: integer-arithmetic reference model checked every cycle plus directed literals.
module tb_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] fsel;
    logic [7:0] reg_out;
    logic [7:0] mul_high;
    logic [3:0] SREG;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [7:0] exp_res;
    logic [7:0] exp_hi;
    logic [3:0] exp_sreg;

    alu #(.WIDTH(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .A                     (A),
        .B                     (B),
        .function_select_lines (fsel),
        .reg_out               (reg_out),
        .mul_high              (mul_high),
        .SREG                  (SREG)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {mul_high, reg_out, C, Z, N, V}.
    function automatic logic [19:0] model(input int op, input int a, input int b);
        int n, sa, sb, sr, res, hi, fl, sc;
        logic [7:0] rb, hb;
        bit c, v, z, ng;
        n  = b % 8;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        hi = 0; c = 0; v = 0; sc = 0; res = 0; fl = -1;
        case (op)
            0: begin
                res = (a + b) % 256; c = (a + b) > 255;
                sr = sa + sb; v = (sr > 127) || (sr < -128);
            end
            1, 3: begin
                res = (a - b + 256) % 256; c = (a < b);
                sr = sa - sb; v = (sr > 127) || (sr < -128);
                fl = res;
                if (op == 3) res = (a > b) ? 4 : ((a == b) ? 2 : 1);
            end
            2: begin
                res = (a * b) % 256; hi = (a * b) / 256; c = (hi != 0); v = c;
            end
            4:  res = a & b;
            5:  res = a | b;
            6:  res = a ^ b;
            7:  res = 255 - a;
            8: begin
                res = (a << n) % 256; sc = (n > 0) ? (a >> (8 - n)) % 2 : 0;
            end
            9: begin
                res = a >> n; sc = (n > 0) ? (a >> (n - 1)) % 2 : 0;
            end
            10: begin
                res = (sa >>> n) & 255; sc = (n > 0) ? (a >> (n - 1)) % 2 : 0;
            end
            11: begin
                res = ((a << n) | (a >> (8 - n))) & 255; sc = (n > 0) ? (a >> (8 - n)) % 2 : 0;
            end
            12: begin
                res = ((a >> n) | (a << (8 - n))) & 255; sc = (n > 0) ? (a >> (n - 1)) % 2 : 0;
            end
            13: res = 255 - (a & b);
            14: res = 255 - (a | b);
            default: res = 255 - (a ^ b);
        endcase
`ifdef ALU_SHIFT_CARRY_EN
        if (op >= 8 && op <= 12) c = (sc != 0);
`endif
        if (op != 3) fl = res;
        z  = (fl == 0);
        ng = (fl >= 128);
        rb = res[7:0];
        hb = hi[7:0];
        return {hb, rb, c, z, ng, v};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_res  <= '0;
            exp_hi   <= '0;
            exp_sreg <= '0;
        end else begin
            {exp_hi, exp_res, exp_sreg} <= model(int'(fsel), int'(A), int'(B));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_reg_out", {24'd0, reg_out}, {24'd0, exp_res});
            chk("model_mul_high", {24'd0, mul_high}, {24'd0, exp_hi});
            chk("model_sreg", {28'd0, SREG}, {28'd0, exp_sreg});
        end
    end

    task automatic apply_chk(input string nm, input logic [3:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] er, input logic [7:0] eh,
                             input logic [3:0] es);
        @(negedge clk);
        fsel = op; A = a; B = b;
        @(posedge clk);
        #1;
        chk({nm, "_res"}, {24'd0, reg_out}, {24'd0, er});
        chk({nm, "_hi"}, {24'd0, mul_high}, {24'd0, eh});
        chk({nm, "_sreg"}, {28'd0, SREG}, {28'd0, es});
    endtask

    logic [7:0] av [9] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'hA5, 8'h3C, 8'h01, 8'hFF, 8'h96};
    logic [7:0] bv [9] = '{8'h00, 8'h01, 8'hFF, 8'h01, 8'h07, 8'h08, 8'h80, 8'hFF, 8'h0C};

    initial begin
        rst = 1'b1; A = 8'hFF; B = 8'h03; fsel = 4'd2;
        #3;
        chk("reset_res", {24'd0, reg_out}, 32'd0);
        chk("reset_hi", {24'd0, mul_high}, 32'd0);
        chk("reset_sreg", {28'd0, SREG}, 32'd0);
        chk_en = 1'b1;

        chk("pin_model_add", {12'd0, model(0, 127, 125)}, {12'd0, 20'h00FC3});
        chk("pin_model_mul", {12'd0, model(2, 120, 85)}, {12'd0, 20'h27D8B});
`ifdef ALU_SHIFT_CARRY_EN
        chk("pin_model_sar", {12'd0, model(10, 8'h81, 1)}, {12'd0, 20'h00C0A});
`else
        chk("pin_model_sar", {12'd0, model(10, 8'h81, 1)}, {12'd0, 20'h00C02});
`endif

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_release_hold", {24'd0, reg_out}, 32'd0);

        apply_chk("add", 4'd0, 8'd127, 8'd125, 8'hFC, 8'h00, 4'b0011);
        apply_chk("sub", 4'd1, 8'd5, 8'd5, 8'h00, 8'h00, 4'b0100);
        apply_chk("cmp", 4'd3, 8'd3, 8'd6, 8'h01, 8'h00, 4'b1010);
        apply_chk("mul", 4'd2, 8'd120, 8'd85, 8'hD8, 8'h27, 4'b1011);
        apply_chk("xor", 4'd6, 8'd13, 8'd85, 8'h58, 8'h00, 4'b0000);
`ifdef ALU_SHIFT_CARRY_EN
        apply_chk("shl", 4'd8, 8'd13, 8'd85, 8'hA0, 8'h00, 4'b1010);
        apply_chk("rol", 4'd11, 8'h81, 8'd1, 8'h03, 8'h00, 4'b1000);
`else
        apply_chk("shl", 4'd8, 8'd13, 8'd85, 8'hA0, 8'h00, 4'b0010);
        apply_chk("rol", 4'd11, 8'h81, 8'd1, 8'h03, 8'h00, 4'b0000);
`endif
        apply_chk("shr0", 4'd9, 8'hB7, 8'd8, 8'hB7, 8'h00, 4'b0010);

        // Reset asserted mid-cycle discards the pending MUL.
        @(negedge clk);
        fsel = 4'd2; A = 8'd120; B = 8'd85;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_res", {24'd0, reg_out}, 32'd0);
        chk("midrst_sreg", {28'd0, SREG}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_hold_hi", {24'd0, mul_high}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_first_res", {24'd0, reg_out}, 32'hD8);
        chk("midrst_first_hi", {24'd0, mul_high}, 32'h27);

        for (int op = 0; op < 16; op++) begin
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                fsel = op[3:0]; A = av[i]; B = bv[i];
            end
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
